// File: rtl/vend_ctrl.sv
// Vending machine controller: collects Q/D/N coins, requests a dispense at PRICE,
// and returns change or a full refund one coin pulse per cycle.
module vend_ctrl #(
  parameter int unsigned PRICE       = 75,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Q_in,
  input  logic                D_in,
  input  logic                N_in,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                chg_q,
  output logic                chg_d,
  output logic                chg_n,
  output logic                coin_reject,
  output logic                fault,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {StIdle, StCollect, StDispense, StChange} state_e;

  // Counter only needs to reach ACK_TIMEOUT-1; the timeout fires on that value.
  localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);

  localparam logic [CREDIT_W-1:0] Price = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] Val25 = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] Val10 = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] Val5  = CREDIT_W'(5);

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  fault_q, fault_d;

  logic                  coin_any;
  logic                  coin_multi;
  logic                  accept;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W-1:0]   chg_val;

  assign coin_any   = Q_in | D_in | N_in;
  assign coin_multi = (Q_in & D_in) | (Q_in & N_in) | (D_in & N_in);

  always_comb begin
    coin_val = '0;
    if (Q_in) begin
      coin_val = Val25;
    end else if (D_in) begin
      coin_val = Val10;
    end else if (N_in) begin
      coin_val = Val5;
    end
  end

  // Change pulses are decoded from state and credit, so they are Moore outputs.
  always_comb begin
    chg_q = 1'b0;
    chg_d = 1'b0;
    chg_n = 1'b0;
    if (state_q == StChange && credit_q != '0) begin
      if (credit_q >= Val25) begin
        chg_q = 1'b1;
      end else if (credit_q >= Val10) begin
        chg_d = 1'b1;
      end else begin
        chg_n = 1'b1;
      end
    end
  end

  always_comb begin
    chg_val = '0;
    if (chg_q) begin
      chg_val = Val25;
    end else if (chg_d) begin
      chg_val = Val10;
    end else if (chg_n) begin
      chg_val = Val5;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = '0;
    fault_d  = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = 1'b1;
        if (coin_any) begin
          credit_d = credit_q + coin_val;
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (credit_q >= Price) begin
          credit_d = credit_q - Price;
          state_d  = StDispense;
        end else if (cancel) begin
          state_d = StChange;
        end else begin
          accept = 1'b1;
          if (coin_any) begin
            credit_d = credit_q + coin_val;
          end
        end
      end
      StDispense: begin
        if (disp_ack) begin
          state_d = (credit_q != '0) ? StChange : StIdle;
        end else if (tmo_q == TmoLast) begin
          // Item never left the mechanism: give the price back along with any change.
          fault_d  = 1'b1;
          credit_d = credit_q + Price;
          state_d  = StChange;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StChange: begin
        if (credit_q == '0) begin
          state_d = StIdle;
        end else begin
          credit_d = credit_q - chg_val;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepting state keeps the highest-priority coin; everything else bounces.
    coin_reject_d = accept ? coin_multi : coin_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      tmo_q         <= '0;
      coin_reject_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmo_q         <= tmo_d;
      coin_reject_q <= coin_reject_d;
      fault_q       <= fault_d;
    end
  end

  assign disp_req    = (state_q == StDispense);
  assign busy        = (state_q == StDispense) || (state_q == StChange);
  assign coin_reject = coin_reject_q;
  assign fault       = fault_q;
  assign credit      = credit_q;

endmodule
